// File: rtl/calc_pkg.sv
// Shared definitions for the calculator core / display interface.
package calc_pkg;

   localparam int unsigned NUM_DIGITS = 8;

   // Core status encodings on the display interface
   localparam logic [1:0] ST_ERRO  = 2'b00;
   localparam logic [1:0] ST_BUSY  = 2'b01;
   localparam logic [1:0] ST_READY = 2'b10;
   localparam logic [1:0] ST_PRINT = 2'b11;

   // Active-low 7-segment glyphs, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_R     = 7'b0101111;
   localparam logic [6:0] SEG_O     = 7'b0100011;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic {
      ModeNormal,
      ModeError
   } mode_e;

endpackage

// File: rtl/seg7_decoder.sv
// Decimal digit to active-low 7-segment glyph; values 10-15 decode to blank.
module seg7_decoder
   import calc_pkg::*;
(
   input  logic [3:0] value_i,
   output logic [6:0] seg_o
);

   // Glyph lookup
   always_comb begin
      seg_o = SEG_BLANK;
      case (value_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/calc_display.sv
// Display end of the calculator: 8-digit memory written by the core, scanned onto a
// multiplexed active-low 7-segment bus, with a fixed "Erro" message once the core errors.
module calc_display
   import calc_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 100000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] status,
   input  logic [3:0] data,
   input  logic [3:0] pos,
   output logic [7:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   // Keep the prescaler at least one bit wide so SCAN_DIV=1 is legal
   localparam int unsigned PresW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [PresW-1:0]                prescaler_q, prescaler_d;
   logic [2:0]                      scan_idx_q, scan_idx_d;
   logic [NUM_DIGITS-1:0][3:0]      digit_q, digit_d;
   logic [NUM_DIGITS-1:0]           valid_q, valid_d;
   logic [1:0]                      prev_status_q;
   mode_e                           mode_q, mode_d;
   logic [7:0]                      an_q, an_d;
   logic [6:0]                      seg_q, seg_d;
   logic [6:0]                      dec_seg;
   logic                            wrap;

   seg7_decoder u_dec (
      .value_i (digit_q[scan_idx_q]),
      .seg_o   (dec_seg)
   );

   // Prescaler wraps at SCAN_DIV-1 and steps the scan slot on that cycle
   always_comb begin
      wrap        = (32'(prescaler_q) == SCAN_DIV - 1);
      prescaler_d = wrap ? '0 : prescaler_q + 1'b1;
      scan_idx_d  = wrap ? scan_idx_q + 3'd1 : scan_idx_q;
   end

   // Mode FSM plus memory writes and busy-edge clears; all frozen once in error
   always_comb begin
      mode_d  = mode_q;
      digit_d = digit_q;
      valid_d = valid_q;
      unique case (mode_q)
         ModeNormal: begin
            if (status == ST_ERRO) begin
               mode_d = ModeError;
            end else if (status == ST_PRINT && pos < 4'(NUM_DIGITS)) begin
               digit_d[pos[2:0]] = data;
               valid_d[pos[2:0]] = 1'b1;
            end else if (status == ST_BUSY && prev_status_q != ST_BUSY) begin
               valid_d = '0;
            end
         end
         ModeError: mode_d = ModeError;
         default:   mode_d = ModeNormal;
      endcase
   end

   // Output stage: anode/segment pattern for the current slot, registered next edge
   always_comb begin
      an_d  = 8'hFF;
      seg_d = SEG_BLANK;
      if (mode_q == ModeError) begin
         case (scan_idx_q)
            3'd3:       seg_d = SEG_E;
            3'd2, 3'd1: seg_d = SEG_R;
            3'd0:       seg_d = SEG_O;
            default:    seg_d = SEG_BLANK;
         endcase
         if (!scan_idx_q[2]) an_d = ~(8'd1 << scan_idx_q);
      end else if (valid_q[scan_idx_q] && digit_q[scan_idx_q] <= 4'd9) begin
         an_d  = ~(8'd1 << scan_idx_q);
         seg_d = dec_seg;
      end
   end

   // State registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prescaler_q   <= '0;
         scan_idx_q    <= '0;
         digit_q       <= '0;
         valid_q       <= '0;
         prev_status_q <= ST_READY;
         mode_q        <= ModeNormal;
         an_q          <= 8'hFF;
         seg_q         <= SEG_BLANK;
      end else begin
         prescaler_q   <= prescaler_d;
         scan_idx_q    <= scan_idx_d;
         digit_q       <= digit_d;
         valid_q       <= valid_d;
         prev_status_q <= status;
         mode_q        <= mode_d;
         an_q          <= an_d;
         seg_q         <= seg_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = 1'b1;

endmodule

// File: tb/tb_calc_display.sv
// Directed bench for calc_display with SCAN_DIV=4 (one full scan = 32 cycles).
module tb_calc_display;

   localparam int unsigned SCAN_DIV = 4;

   localparam logic [6:0] B  = 7'b1111111;
   localparam logic [6:0] G1 = 7'b1111001;
   localparam logic [6:0] G2 = 7'b0100100;
   localparam logic [6:0] G3 = 7'b0110000;
   localparam logic [6:0] G4 = 7'b0011001;
   localparam logic [6:0] G5 = 7'b0010010;
   localparam logic [6:0] G6 = 7'b0000010;
   localparam logic [6:0] G7 = 7'b1111000;
   localparam logic [6:0] G8 = 7'b0000000;
   localparam logic [6:0] GE = 7'b0000110;
   localparam logic [6:0] GR = 7'b0101111;
   localparam logic [6:0] GO = 7'b0100011;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] status;
   logic [3:0] data;
   logic [3:0] pos;
   logic [7:0] an;
   logic [6:0] seg;
   logic       dp;

   int checks = 0;
   int errors = 0;
   int n = 0;  // clock edges since the last reset release

   always #5 clock = ~clock;

   calc_display #(.SCAN_DIV(SCAN_DIV)) dut (
      .clock  (clock),
      .reset  (reset),
      .status (status),
      .data   (data),
      .pos    (pos),
      .an     (an),
      .seg    (seg),
      .dp     (dp)
   );

   task automatic tick();
      @(posedge clock);
      n++;
      #1;
   endtask

   task automatic run(input int cycles);
      for (int i = 0; i < cycles; i++) tick();
   endtask

   task automatic chk(input string tag, input logic [7:0] ean, input logic [6:0] eseg);
      checks++;
      assert (an === ean && seg === eseg && dp === 1'b1)
      else begin
         errors++;
         $error("FAIL %s: got an=%h seg=%b dp=%b, expected an=%h seg=%b dp=1",
                tag, an, seg, dp, ean, eseg);
      end
   endtask

   // One full scan; output after edge n shows the slot held before that edge
   task automatic check_scan(input string tag, input logic [7:0][6:0] eseg);
      int         slot;
      logic [7:0] ean;
      for (int i = 0; i < 32; i++) begin
         tick();
         slot = ((n - 1) / int'(SCAN_DIV)) % 8;
         ean  = (eseg[slot] === B) ? 8'hFF : ~(8'h01 << slot);
         chk($sformatf("%s slot%0d", tag, slot), ean, eseg[slot]);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      n = 0;
   endtask

   initial begin
      status = 2'b10;
      data   = 4'd0;
      pos    = 4'd0;
      #2 reset = 1'b1;
      #1 chk("reset", 8'hFF, B);
      do_reset();

      // Empty memory: every slot blank
      check_scan("idle", {B, B, B, B, B, B, B, B});

      // Two writes then ready
      status = 2'b11; pos = 4'd0; data = 4'd4;
      tick();
      pos = 4'd1; data = 4'd2;
      tick();
      status = 2'b10;
      run(32);
      check_scan("write2", {B, B, B, B, B, B, G2, G4});

      // Busy clears validity; holding busy keeps everything blank
      status = 2'b01;
      run(5);
      check_scan("busy", {B, B, B, B, B, B, B, B});
      status = 2'b11; pos = 4'd0; data = 4'd7;
      tick();
      status = 2'b10;
      run(32);
      check_scan("rewrite", {B, B, B, B, B, B, B, G7});

      // Clear, then an out-of-range position and a non-decimal value
      status = 2'b01;
      tick();
      status = 2'b10;
      tick();
      status = 2'b11; pos = 4'd9; data = 4'd5;
      tick();
      pos = 4'd3; data = 4'd12;
      tick();
      status = 2'b10;
      run(32);
      check_scan("badwrite", {B, B, B, B, B, B, B, B});

      // Fill all digits with 1..8
      status = 2'b11;
      for (int i = 0; i < 8; i++) begin
         pos  = 4'(i);
         data = 4'(i + 1);
         tick();
      end
      status = 2'b10;
      run(32);
      check_scan("fill", {G8, G7, G6, G5, G4, G3, G2, G1});

      // Error for one cycle, then a write that must be ignored
      status = 2'b00;
      tick();
      status = 2'b11; pos = 4'd0; data = 4'd9;
      tick();
      status = 2'b10;
      run(32);
      check_scan("error", {B, B, B, B, GE, GR, GR, GO});

      // Busy edge and further writes do not leave the error state
      status = 2'b01;
      tick();
      status = 2'b11; pos = 4'd5; data = 4'd1;
      tick();
      status = 2'b10;
      run(32);
      check_scan("error_hold", {B, B, B, B, GE, GR, GR, GO});

      // Reset recovers; relight all digits, then reset asynchronously mid-slot
      do_reset();
      check_scan("post_err_reset", {B, B, B, B, B, B, B, B});
      status = 2'b11;
      for (int i = 0; i < 8; i++) begin
         pos  = 4'(i);
         data = 4'(i + 1);
         tick();
      end
      status = 2'b10;
      run(33);
      checks++;
      assert (an !== 8'hFF)
      else begin
         errors++;
         $error("FAIL prelit: got an=%h, expected a lit anode", an);
      end
      reset = 1'b1;
      #1 chk("async_reset", 8'hFF, B);
      @(negedge clock);
      reset = 1'b0;
      n = 0;
      check_scan("mem_cleared", {B, B, B, B, B, B, B, B});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
